// File: rtl/register_file_rw_pkg.sv
// rtl/register_file_rw_pkg.sv - project-wide datapath and register file definitions
package register_file_rw_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int REG_ADDR_WIDTH       = 5;
    localparam int REG_ADDR_INDEX_LIMIT = REG_ADDR_WIDTH - 1;
    localparam int NUM_OF_REG           = 2 ** REG_ADDR_WIDTH;

    typedef logic [DATA_INDEX_LIMIT:0]     data_t;
    typedef logic [REG_ADDR_INDEX_LIMIT:0] reg_addr_t;

endpackage

// File: rtl/register_bank.sv
// rtl/register_bank.sv - register storage with one write port and two combinational read muxes
module register_bank
    import register_file_rw_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH,
    parameter int N  = NUM_OF_REG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem [N];

    // An unknown enable takes the else path, so X/Z never commits a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/register_file_rw.sv
// rtl/register_file_rw.sv - 2R1W register file with r0 masking, write bypass and registered outputs
module register_file_rw #(
    parameter int DATA_WIDTH = register_file_rw_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_rw_pkg::REG_ADDR_WIDTH,
    parameter int REG_COUNT  = register_file_rw_pkg::NUM_OF_REG
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  DATA_VALID
);

    logic                  write_en;
    logic [DATA_WIDTH-1:0] bank_r1;
    logic [DATA_WIDTH-1:0] bank_r2;
    logic [DATA_WIDTH-1:0] next_r1;
    logic [DATA_WIDTH-1:0] next_r2;

    assign write_en = WRITE && (ADDR_W != '0);

    register_bank #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH),
        .N  (REG_COUNT)
    ) u_bank (
        .clk    (CLK),
        .rst    (RST),
        .we     (write_en),
        .waddr  (ADDR_W),
        .wdata  (DATA_W),
        .raddr1 (ADDR_R1),
        .raddr2 (ADDR_R2),
        .rdata1 (bank_r1),
        .rdata2 (bank_r2)
    );

    // r0 masking first, then forward the ALU write-back so the next fetch needs no stall.
    always_comb begin
        next_r1 = bank_r1;
        if (ADDR_R1 == '0) begin
            next_r1 = '0;
        end else if (write_en && (ADDR_W == ADDR_R1)) begin
            next_r1 = DATA_W;
        end
    end

    always_comb begin
        next_r2 = bank_r2;
        if (ADDR_R2 == '0) begin
            next_r2 = '0;
        end else if (write_en && (ADDR_W == ADDR_R2)) begin
            next_r2 = DATA_W;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_R1    <= '0;
            DATA_R2    <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= READ;
            if (READ) begin
                DATA_R1 <= next_r1;
                DATA_R2 <= next_r2;
            end
        end
    end

endmodule

// File: tb/tb_register_file_rw.sv
// tb/tb_register_file_rw.sv - scoreboard testbench for register_file_rw
module tb_register_file_rw;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        v;

    typedef struct packed {
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
    } out_t;

    out_t        exp_q[$];
    out_t        obs_q[$];
    logic [31:0] mreg [32];
    out_t        mout;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    register_file_rw dut (
        .CLK        (clk),
        .RST        (rst),
        .READ       (rd),
        .WRITE      (wr),
        .ADDR_R1    (a1),
        .ADDR_R2    (a2),
        .ADDR_W     (aw),
        .DATA_W     (dw),
        .DATA_R1    (r1),
        .DATA_R2    (r2),
        .DATA_VALID (v)
    );

    // Applies one cycle of stimulus, pushes the expected outputs, records the observed ones.
    task automatic drive(input logic r, input logic rdi, input logic wri,
                         input logic [4:0] x1, input logic [4:0] x2,
                         input logic [4:0] xw, input logic [31:0] d);
        logic [31:0] v1;
        logic [31:0] v2;
        rst = r; rd = rdi; wr = wri; a1 = x1; a2 = x2; aw = xw; dw = d;
        if (r) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            mout = '0;
        end else begin
            v1 = (x1 == 0) ? 32'd0 : ((wri && xw == x1) ? d : mreg[x1]);
            v2 = (x2 == 0) ? 32'd0 : ((wri && xw == x2) ? d : mreg[x2]);
            mout.valid = rdi;
            if (rdi) begin
                mout.d1 = v1;
                mout.d2 = v2;
            end
            if (wri && xw != 0) mreg[xw] = d;
        end
        exp_q.push_back(mout);
        @(posedge clk);
        #1;
        obs_q.push_back({v, r1, r2});
    endtask

    task automatic test_reset;
        out_t e, o;
        int   n = 0;
        drive(1, 0, 1, 0, 0, 5, 32'hDEAD_BEEF);
        drive(1, 0, 1, 0, 0, 5, 32'hDEAD_BEEF);
        drive(0, 1, 0, 5, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_write_read;
        out_t e, o;
        int   n = 0;
        drive(0, 0, 1, 0, 0, 1, 32'd15);
        drive(0, 0, 1, 0, 0, 2, 32'd3);
        drive(0, 1, 0, 1, 2, 0, 0);
        checks++;
        if (r1 + r2 !== 32'd18) begin
            errors++;
            $display("FAIL alu_add got %0d want 18", r1 + r2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL write_read[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_bypass;
        out_t e, o;
        int   n = 0;
        drive(0, 0, 1, 0, 0, 7, 32'd7);
        drive(0, 1, 1, 7, 7, 7, 32'hFFFF_FFFB);
        drive(0, 1, 0, 7, 7, 0, 0);
        drive(0, 1, 1, 7, 1, 1, 32'h0000_0021);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bypass[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_r0;
        out_t e, o;
        int   n = 0;
        drive(0, 0, 1, 0, 0, 0, 32'h1234_5678);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 32'hCAFE_F00D);
        drive(0, 1, 0, 0, 2, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL r0[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back;
        out_t e, o;
        int   n = 0;
        drive(0, 1, 0, 1, 2, 0, 0);
        drive(0, 1, 0, 7, 1, 0, 0);
        drive(0, 1, 0, 2, 7, 0, 0);
        drive(0, 0, 0, 3, 4, 0, 0);
        drive(0, 0, 1, 2, 7, 9, 32'h0BAD_0BAD);
        drive(0, 0, 1, 2, 7, 2, 32'h5555_AAAA);
        drive(0, 1, 0, 9, 2, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_random;
        out_t e, o;
        int   n = 0;
        for (int i = 0; i < 60; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    task automatic test_reset_midstream;
        out_t e, o;
        int   n = 0;
        drive(0, 0, 1, 0, 0, 31, 32'hA5A5_5A5A);
        drive(0, 1, 0, 1, 31, 0, 0);
        drive(1, 1, 1, 1, 31, 3, 32'h1111_1111);
        checks++;
        if (v !== 1'b0 || r1 !== 32'd0 || r2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got v=%0b r1=%h r2=%h want v=0 r1=0 r2=0", v, r1, r2);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 5'(2 * i), 5'(2 * i + 1), 0, 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d] got v=%0b r1=%h r2=%h want v=%0b r1=%h r2=%h",
                         n, o.valid, o.d1, o.d2, e.valid, e.d1, e.d2);
            end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        a1 = '0; a2 = '0; aw = '0; dw = '0;
        mout = '0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
